// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: EX operand forwarding selects,
// load-use and mul/div hazard stalls, branch flush, and the shared mul/div busy/done sequencer.
module hazard_fwd_ctrl #(
    parameter int MD_LATENCY = 8,
    parameter int RA_W       = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_md_op,
    input  logic [RA_W-1:0] ex_rs1,
    input  logic [RA_W-1:0] ex_rs2,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_memread,
    input  logic            ex_md_start,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_regwrite,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_regwrite,
    input  logic            branch_taken,
    output logic [1:0]      ForwardA,
    output logic [1:0]      ForwardB,
    output logic            stall,
    output logic            bubble_ex,
    output logic            flush_if_id,
    output logic            md_busy,
    output logic            md_done,
    output logic [RA_W-1:0] md_rd,
    output logic            md_overrun,
    output logic [31:0]     stall_cnt
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    localparam logic [7:0] CNT_INIT = 8'(MD_LATENCY - 1);

    md_state_t  state;
    md_state_t  next_state;
    logic [7:0] md_cnt;
    logic       load_use;
    logic       md_hazard;
    logic       md_capture;

    // MEM stage result is newer than WB, so it wins when both match.
    always_comb begin
        ForwardA = 2'b00;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs1))
            ForwardA = 2'b10;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs1))
            ForwardA = 2'b01;

        ForwardB = 2'b00;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs2))
            ForwardB = 2'b10;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs2))
            ForwardB = 2'b01;
    end

    assign load_use  = ex_memread && (ex_rd != '0) && id_valid &&
                       ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign md_hazard = md_busy && id_valid &&
                       (((md_rd != '0) && ((id_rs1 == md_rd) || (id_rs2 == md_rd))) || id_md_op);

    // A taken branch kills the ID instruction, so any hazard it had is moot.
    assign stall       = (load_use || md_hazard) && !branch_taken;
    assign bubble_ex   = stall || branch_taken;
    assign flush_if_id = branch_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ex_md_start) next_state = BUSY;
            BUSY:    if (md_cnt == 8'd1) next_state = DONE;
            DONE:    next_state = ex_md_start ? BUSY : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        md_busy = (state != IDLE);
        md_done = (state == DONE);
    end

    // A new operation may be accepted from IDLE or in the DONE cycle; starts while BUSY are dropped.
    assign md_capture = ex_md_start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_cnt     <= '0;
            md_rd      <= '0;
            md_overrun <= 1'b0;
        end else begin
            if (md_capture) begin
                md_rd  <= ex_rd;
                md_cnt <= CNT_INIT;
            end else if (state == BUSY) begin
                md_cnt <= md_cnt - 8'd1;
            end
            if ((state == BUSY) && ex_md_start)
                md_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed testbench for hazard_fwd_ctrl: forwarding priority, load-use, branch priority,
// mul/div sequencing with back-to-back/overrun, and asynchronous reset mid-operation.
module tb_hazard_fwd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_md_op;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic        ex_memread;
    logic        ex_md_start;
    logic [4:0]  mem_rd;
    logic        mem_regwrite;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic        branch_taken;
    logic [1:0]  ForwardA;
    logic [1:0]  ForwardB;
    logic        stall;
    logic        bubble_ex;
    logic        flush_if_id;
    logic        md_busy;
    logic        md_done;
    logic [4:0]  md_rd;
    logic        md_overrun;
    logic [31:0] stall_cnt;

    int checkCount = 0;
    int errorCount = 0;

    hazard_fwd_ctrl #(.MD_LATENCY(8), .RA_W(5)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_md_op(id_md_op),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
        .ex_md_start(ex_md_start),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .branch_taken(branch_taken),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .stall(stall), .bubble_ex(bubble_ex), .flush_if_id(flush_if_id),
        .md_busy(md_busy), .md_done(md_done), .md_rd(md_rd),
        .md_overrun(md_overrun), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic clearInputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_md_op = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_memread = 0; ex_md_start = 0;
        mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0; branch_taken = 0;
    endtask

    // Advance to just after the next rising edge, then drive the mul/div issue inputs.
    task automatic applyStimulus(input logic start, input logic [4:0] rd);
        @(posedge clk);
        #1;
        ex_md_start = start;
        ex_rd       = rd;
        #1;
    endtask

    initial begin
        clearInputs();
        rst = 1'b1;
        #12;
        checkOutput("reset md_busy", 32'(md_busy), 32'd0);
        checkOutput("reset md_done", 32'(md_done), 32'd0);
        checkOutput("reset md_rd", 32'(md_rd), 32'd0);
        checkOutput("reset md_overrun", 32'(md_overrun), 32'd0);
        checkOutput("reset stall_cnt", stall_cnt, 32'd0);
        checkOutput("reset stall", 32'(stall), 32'd0);
        rst = 1'b0;

        // Forwarding priority and rd=0 exclusion
        applyStimulus(1'b0, 5'd0);
        ex_rs1 = 5; mem_rd = 5; wb_rd = 5; mem_regwrite = 1; wb_regwrite = 1; #1;
        checkOutput("fwdA mem priority", 32'(ForwardA), 32'd2);
        mem_regwrite = 0; #1;
        checkOutput("fwdA wb", 32'(ForwardA), 32'd1);
        mem_regwrite = 1; mem_rd = 0; #1;
        checkOutput("fwdA mem rd0 falls to wb", 32'(ForwardA), 32'd1);
        ex_rs1 = 0; wb_rd = 0; #1;
        checkOutput("fwdA rd0", 32'(ForwardA), 32'd0);
        ex_rs2 = 3; wb_rd = 3; mem_rd = 4; #1;
        checkOutput("fwdB wb", 32'(ForwardB), 32'd1);
        mem_rd = 3; #1;
        checkOutput("fwdB mem", 32'(ForwardB), 32'd2);
        clearInputs();

        // Load-use
        applyStimulus(1'b0, 5'd7);
        ex_memread = 1; id_rs2 = 7; id_valid = 1; #1;
        checkOutput("loaduse stall", 32'(stall), 32'd1);
        checkOutput("loaduse bubble", 32'(bubble_ex), 32'd1);
        checkOutput("loaduse flush", 32'(flush_if_id), 32'd0);
        applyStimulus(1'b0, 5'd0);
        clearInputs(); #1;
        checkOutput("loaduse stall_cnt", stall_cnt, 32'd1);
        checkOutput("loaduse released", 32'(stall), 32'd0);
        ex_memread = 1; ex_rd = 7; id_rs2 = 7; id_valid = 0; #1;
        checkOutput("loaduse id_valid0", 32'(stall), 32'd0);
        ex_rd = 0; id_rs2 = 0; id_valid = 1; #1;
        checkOutput("loaduse rd0", 32'(stall), 32'd0);

        // Branch beats stall
        ex_rd = 7; id_rs1 = 7; branch_taken = 1; #1;
        checkOutput("branch stall", 32'(stall), 32'd0);
        checkOutput("branch flush", 32'(flush_if_id), 32'd1);
        checkOutput("branch bubble", 32'(bubble_ex), 32'd1);
        applyStimulus(1'b0, 5'd0);
        clearInputs(); #1;
        checkOutput("branch stall_cnt", stall_cnt, 32'd1);

        // Single mul/div with dependent ID instruction
        applyStimulus(1'b1, 5'd9);
        id_valid = 1; id_rs1 = 9; #1;
        checkOutput("md c0 busy", 32'(md_busy), 32'd0);
        checkOutput("md c0 stall", 32'(stall), 32'd0);
        for (int c = 1; c <= 8; c++) begin
            applyStimulus(1'b0, 5'd0);
            checkOutput($sformatf("md c%0d busy", c), 32'(md_busy), 32'd1);
            checkOutput($sformatf("md c%0d done", c), 32'(md_done), 32'(c == 8));
            checkOutput($sformatf("md c%0d rd", c), 32'(md_rd), 32'd9);
            checkOutput($sformatf("md c%0d stall", c), 32'(stall), 32'd1);
        end
        applyStimulus(1'b0, 5'd0);
        checkOutput("md c9 busy", 32'(md_busy), 32'd0);
        checkOutput("md c9 done", 32'(md_done), 32'd0);
        checkOutput("md c9 stall", 32'(stall), 32'd0);
        checkOutput("md c9 stall_cnt", stall_cnt, 32'd9);
        clearInputs();

        // Overrun during BUSY, then back-to-back start in DONE
        applyStimulus(1'b1, 5'd10);
        for (int c = 1; c <= 16; c++) begin
            applyStimulus(c == 3 || c == 8, (c == 3) ? 5'd11 : ((c == 8) ? 5'd12 : 5'd0));
            checkOutput($sformatf("b2b c%0d busy", c), 32'(md_busy), 32'd1);
            checkOutput($sformatf("b2b c%0d done", c), 32'(md_done), 32'(c == 8 || c == 16));
            checkOutput($sformatf("b2b c%0d rd", c), 32'(md_rd), (c <= 8) ? 32'd10 : 32'd12);
            checkOutput($sformatf("b2b c%0d overrun", c), 32'(md_overrun), 32'(c >= 4));
            if (c == 2) begin
                id_valid = 1; id_md_op = 1; id_rs1 = 1; id_rs2 = 2; #1;
                checkOutput("md_op stall", 32'(stall), 32'd1);
                clearInputs(); #1;
            end
        end
        applyStimulus(1'b0, 5'd0);
        checkOutput("b2b idle busy", 32'(md_busy), 32'd0);
        checkOutput("b2b idle rd hold", 32'(md_rd), 32'd12);
        checkOutput("b2b idle overrun", 32'(md_overrun), 32'd1);
        checkOutput("b2b stall_cnt", stall_cnt, 32'd9);

        // Asynchronous reset in cycle 4 of an operation
        applyStimulus(1'b1, 5'd13);
        id_valid = 1; id_rs1 = 13;
        for (int c = 1; c <= 4; c++)
            applyStimulus(1'b0, 5'd0);
        checkOutput("pre-reset stall_cnt", stall_cnt, 32'd12);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async rst busy", 32'(md_busy), 32'd0);
        checkOutput("async rst overrun", 32'(md_overrun), 32'd0);
        checkOutput("async rst stall_cnt", stall_cnt, 32'd0);
        checkOutput("async rst md_rd", 32'(md_rd), 32'd0);
        applyStimulus(1'b0, 5'd0);
        rst = 1'b0;
        clearInputs();
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b0, 5'd0);
            checkOutput($sformatf("post-rst c%0d done", c), 32'(md_done), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
